logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the single 2-input gate: a WIDTH-bit bitwise logic unit with run-time selectable operation (AND/OR/NAND/NOR/XOR/XNOR/NOT/BUF).
- A two-stage registered pipeline with valid/ready handshake on both sides.
- Sits between a stimulus/source block and any consumer of logic results. Sustains one result per clock when the consumer is ready.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept beat this cycle
- in_op  input  3  operation select (encoding below)
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result this cycle
- out_y  output  WIDTH  result
- out_zero  output  1  out_y == 0
- out_op  output  3  op that produced out_y
- op_count  output  16  accepted-result counter (only with LOGIC_STATS_EN)

Behaviour:
- One clock domain, clk. Reset is synchronous, active-low: rst_n sampled low at a rising clk edge resets the block.
- Op encoding (y per bit):
  - 000 AND a&b
  - 001 OR a|b
  - 010 NAND ~(a&b)
  - 011 NOR ~(a|b)
  - 100 XOR a^b
  - 101 XNOR ~(a^b)
  - 110 NOT ~a (b ignored)
  - 111 BUF a (b ignored)
- Stage 1 (S1): registers in_op, in_a, in_b and s1_valid.
- Stage 2 (S2): registers the computed result into out_y, out_zero and out_op, with out_valid = s2_valid.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no bubble).
- S2 load: when s2_adv, S2 loads S1 contents and s2_valid <= s1_valid.
- S1 load: when s1_adv, S1 loads the input and s1_valid <= in_valid && in_ready.
- Hold: when a stage does not advance, it holds all its registers unchanged.
- Latency: 2 clocks from input transfer to out_valid, given no backpressure. Throughput is 1 beat/clock.
- Backpressure: out_ready low with both stages full makes in_ready go low in the same cycle.
  - out_y, out_zero and out_op stay stable while out_valid && !out_ready.
  - No beat is lost or duplicated.
- Ordering: strict FIFO, depth 2 in flight.
- Invalid input: data presented with in_valid low is never captured as valid. Register contents under s1_valid=0 are don't-care but must not reach out_valid.
- Reset values:
  - s1_valid = 0, out_valid = 0.
  - out_y = 0, out_zero = 1, out_op = 000.
  - op_count = 0.
  - in_ready = 1 from the first cycle after reset (combinational; it is 1 as soon as both stages are empty).
- Reset mid-operation: all in-flight beats are discarded, with no out_valid on the following cycle.
- Width rules:
  - All ops are bitwise over WIDTH bits; no carries.
  - out_zero is the NOR-reduction of out_y.
  - WIDTH=1 must elaborate and behave as a registered single gate.

Optional Feature:
- Macro: LOGIC_STATS_EN.
- Defined:
  - Port op_count[15:0] exists.
  - It increments by 1 on every output transfer (out_valid && out_ready).
  - It wraps 0xFFFF -> 0x0000 and resets to 0.
- Undefined: op_count port and counter are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, out_ready=1, a=8'hF0, b=8'hCC, ops 000..111 on consecutive cycles -> out_y on cycles 2..9 = C0, FC, 3F, 03, 3C, C3, 0F, F0, in order; out_op matches.
- WIDTH=1, exhaustive (a,b) in {11, 01, 10, 00} with op=010 -> out_y = 0, 1, 1, 1; out_zero = 1, 0, 0, 0.
- Stream 4 beats (a = 01..04, b = 00, op=111) with out_ready low for cycles 2-4 -> in_ready drops once 2 beats are held; out_y holds 01 stable; outputs 01, 02, 03, 04 exactly once each.
- a=8'hAA, b=8'h55, op=000 -> out_y = 00, out_zero = 1.
- Assert rst_n=0 for one clock with 2 beats in flight -> next cycle out_valid = 0, out_y = 00, in_ready = 1, and no stale beat emerges afterwards.
- LOGIC_STATS_EN defined: preload traffic to 65535 transfers (or force counter to FFFF), then one more transfer -> op_count = 0000. Stalled cycles (out_ready = 0) do not increment.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined WIDTH-bit bitwise logic unit with valid/ready on both sides.
// Optional LOGIC_STATS_EN adds a 16-bit wrapping count of accepted results on op_count.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic [2:0]       out_op
`ifdef LOGIC_STATS_EN
    ,
    output logic [15:0]      op_count
`endif
);

    typedef enum logic [2:0] {
        OpAnd  = 3'b000,
        OpOr   = 3'b001,
        OpNand = 3'b010,
        OpNor  = 3'b011,
        OpXor  = 3'b100,
        OpXnor = 3'b101,
        OpNot  = 3'b110,
        OpBuf  = 3'b111
    } op_e;

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_y_q, s2_y_d;
    logic             s2_zero_q, s2_zero_d;
    logic [2:0]       s2_op_q, s2_op_d;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] s1_y;

    // in_ready is combinational from out_ready so a full pipe still streams without a bubble.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_y = '0;
        unique case (op_e'(s1_op_q))
            OpAnd:   s1_y = s1_a_q & s1_b_q;
            OpOr:    s1_y = s1_a_q | s1_b_q;
            OpNand:  s1_y = ~(s1_a_q & s1_b_q);
            OpNor:   s1_y = ~(s1_a_q | s1_b_q);
            OpXor:   s1_y = s1_a_q ^ s1_b_q;
            OpXnor:  s1_y = ~(s1_a_q ^ s1_b_q);
            OpNot:   s1_y = ~s1_a_q;
            OpBuf:   s1_y = s1_a_q;
            default: s1_y = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_y_d     = s2_y_q;
        s2_zero_d  = s2_zero_q;
        s2_op_d    = s2_op_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            s1_op_d    = in_op;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            s2_y_d     = s1_y;
            s2_zero_d  = ~|s1_y;
            s2_op_d    = s1_op_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 3'b000;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
            s2_zero_q  <= 1'b1;
            s2_op_q    <= 3'b000;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
            s2_zero_q  <= s2_zero_d;
            s2_op_q    <= s2_op_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_y     = s2_y_q;
    assign out_zero  = s2_zero_q;
    assign out_op    = s2_op_q;

`ifdef LOGIC_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count_q <= 16'h0000;
        end else if (out_valid && out_ready) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: truth-table model with an in-flight queue, checked every cycle,
// plus directed vectors with literal expectations (WIDTH=8 and WIDTH=1 instances).
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [2:0] in_op, out_op;
    logic [7:0] in_a, in_b, out_y;

    logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_out_zero;
    logic [2:0] w1_in_op, w1_out_op;
    logic [0:0] w1_in_a, w1_in_b, w1_out_y;

`ifdef LOGIC_STATS_EN
    logic [15:0] op_count, w1_op_count;
`endif

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_op    (out_op)
`ifdef LOGIC_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    logic_unit_pipe #(.WIDTH(1)) dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w1_in_valid),
        .in_ready  (w1_in_ready),
        .in_op     (w1_in_op),
        .in_a      (w1_in_a),
        .in_b      (w1_in_b),
        .out_valid (w1_out_valid),
        .out_ready (1'b1),
        .out_y     (w1_out_y),
        .out_zero  (w1_out_zero),
        .out_op    (w1_out_op)
`ifdef LOGIC_STATS_EN
        ,
        .op_count  (w1_op_count)
`endif
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        else passed++;
    endtask

    // Per-op truth table indexed by {a_bit, b_bit}.
    function automatic logic [7:0] model_y(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [3:0] tt;
        logic [7:0] y;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0111;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0110;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 8; i++) y[i] = tt[{a[i], b[i]}];
        return y;
    endfunction

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        bit         has_lit;
        logic [7:0] lit;
    } beat_t;

    beat_t q[$];
    bit         lit_en;
    logic [7:0] lit_val;
    int         out_cnt = 0;

    // Monitor: mid-cycle, outputs are settled and the upcoming edge's transfers are known.
    initial begin
        bit         stall_q = 0;
        logic [7:0] prev_y = '0;
        logic [2:0] prev_op = '0;
        logic [15:0] exp_cnt = '0;
        logic [7:0] ey;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                stall_q = 0;
                exp_cnt = '0;
            end else begin
                chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_beat", 32'(out_valid), 32'd0);
                    end else begin
                        ey = model_y(q[0].op, q[0].a, q[0].b);
                        chk("out_y", 32'(out_y), 32'(ey));
                        chk("out_zero", 32'(out_zero), 32'(ey == 8'h00));
                        chk("out_op", 32'(out_op), 32'(q[0].op));
                        if (q[0].has_lit) chk("out_y_literal", 32'(out_y), 32'(q[0].lit));
                    end
                end
                if (stall_q) begin
                    chk("stall_valid_held", 32'(out_valid), 32'd1);
                    chk("stall_y_stable", 32'(out_y), 32'(prev_y));
                    chk("stall_op_stable", 32'(out_op), 32'(prev_op));
                end
`ifdef LOGIC_STATS_EN
                chk("op_count", 32'(op_count), 32'(exp_cnt));
`endif
                if (out_valid && out_ready) begin
                    if (q.size() != 0) void'(q.pop_front());
                    out_cnt++;
                    exp_cnt = exp_cnt + 16'd1;
                end
                stall_q = out_valid && !out_ready;
                prev_y  = out_y;
                prev_op = out_op;
                if (in_valid && in_ready) q.push_back('{in_op, in_a, in_b, lit_en, lit_val});
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input bit le, input logic [7:0] lv);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        lit_en   = le;
        lit_val  = lv;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    logic [7:0] lits [8];
    logic       w1a [4];
    logic       w1b [4];
    logic       w1y [4];

    initial begin
        int sent;
        int start_cnt;
        bit saw_low;
        bit acc;
        lits = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        w1a  = '{1'b1, 1'b0, 1'b1, 1'b0};
        w1b  = '{1'b1, 1'b1, 1'b0, 1'b0};
        w1y  = '{1'b0, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        w1_in_valid = 1'b0; w1_in_op = 3'd0; w1_in_a = 1'b0; w1_in_b = 1'b0;
        @(posedge clk);
        cyc();
        rst_n = 1'b1;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'h00);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_w1_out_zero", 32'(w1_out_zero), 32'd1);
`ifdef LOGIC_STATS_EN
        chk("rst_op_count", 32'(op_count), 32'd0);
`endif

        // All eight ops back to back on F0/CC.
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'(i), 8'hF0, 8'hCC, 1, lits[i]);
            cyc();
            if (i == 0) chk("latency_not_yet", 32'(out_valid), 32'd0);
            if (i == 1) begin
                chk("latency_2_valid", 32'(out_valid), 32'd1);
                chk("latency_2_y", 32'(out_y), 32'hC0);
            end
        end
        drive(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        repeat (3) cyc();

        // AND of complementary patterns gives zero.
        drive(1, 3'd0, 8'hAA, 8'h55, 1, 8'h00);
        cyc();
        drive(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        cyc();
        chk("and_aa55_valid", 32'(out_valid), 32'd1);
        chk("and_aa55_y", 32'(out_y), 32'h00);
        chk("and_aa55_zero", 32'(out_zero), 32'd1);
        cyc();

        // WIDTH=1 NAND, exhaustive.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                w1_in_valid = 1'b1; w1_in_op = 3'b010; w1_in_a = w1a[i]; w1_in_b = w1b[i];
            end else begin
                w1_in_valid = 1'b0;
            end
            cyc();
            if (i >= 1) begin
                chk("w1_valid", 32'(w1_out_valid), 32'd1);
                chk("w1_y", 32'(w1_out_y), 32'(w1y[i-1]));
                chk("w1_zero", 32'(w1_out_zero), 32'(!w1y[i-1]));
                chk("w1_op", 32'(w1_out_op), 32'b010);
            end
        end

        // Four BUF beats under a three-cycle stall.
        sent = 0;
        saw_low = 0;
        start_cnt = out_cnt;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            if (sent < 4) drive(1, 3'd7, 8'(sent + 1), 8'h00, 1, 8'(sent + 1));
            else drive(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
            @(negedge clk);
            if (!in_ready) saw_low = 1;
            acc = in_valid && in_ready;
            cyc();
            if (acc) sent++;
        end
        out_ready = 1'b1;
        chk("bp_beats_sent", 32'(sent), 32'd4);
        chk("bp_beats_out", 32'(out_cnt - start_cnt), 32'd4);
        chk("bp_in_ready_dropped", 32'(saw_low), 32'd1);

        // Reset with two beats held in the pipe.
        out_ready = 1'b0;
        drive(1, 3'd1, 8'h11, 8'h22, 0, 8'h00);
        cyc();
        drive(1, 3'd4, 8'h33, 8'h0F, 0, 8'h00);
        cyc();
        drive(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        do_reset();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_y", 32'(out_y), 32'h00);
        chk("midrst_out_zero", 32'(out_zero), 32'd1);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("midrst_no_stale", 32'(out_valid), 32'd0);

`ifdef LOGIC_STATS_EN
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            drive(1, 3'd7, 8'(i), 8'h00, 0, 8'h00);
            cyc();
        end
        drive(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        repeat (3) cyc();
        chk("stats_wrap", 32'(op_count), 32'h0000);
        out_ready = 1'b0;
        drive(1, 3'd0, 8'hFF, 8'h0F, 1, 8'h0F);
        cyc();
        drive(0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        repeat (3) cyc();
        chk("stats_stall_no_inc", 32'(op_count), 32'h0000);
        out_ready = 1'b1;
        cyc();
        chk("stats_after_release", 32'(op_count), 32'h0001);
`endif

        repeat (3) cyc();
        chk("drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
